spi_cmd_decoder: RTL

- Downstream consumer of the front-panel SPI slave receiver.
- Brings that receiver's byte flag and chip-select into the system clock domain and parses each SPI frame as one command byte followed by data bytes.
- Writes the data into a small register file that drives front-panel outputs (LED banks, digit latches).
- Supports burst writes with address auto-increment.

---
 rtl/spi_cmd_decoder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Parses SPI frames (command byte + data bytes) coming from the front-panel
// SPI slave receiver and writes the data into a small register file.
// The chip-select and byte flag are synchronised into the CLK domain here.
// Ports:
//   CLK        system clock, rising edge
//   RESETN     synchronous active-low reset
//   SS         SPI chip select (active low, asynchronous)
//   BYTE_IN    received byte (asynchronous, stable while flagged)
//   BYTE_FLAG  byte-complete flag (asynchronous, active high)
//   REGS       flattened register file, reg n at [8n+7:8n]
//   WR_STROBE  one-cycle pulse when a register is written
//   WR_ADDR    address of the last written register
//   CMD_ERR    one-cycle pulse on an illegal command byte
//   BUSY       high while a frame is being parsed
module spi_cmd_decoder #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  SS,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_FLAG,
  output logic [NREGS*8-1:0]    REGS,
  output logic                  WR_STROBE,
  output logic [ADDR_W-1:0]     WR_ADDR,
  output logic                  CMD_ERR,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic ss_meta_q, ss_meta_d, ss_sync_q, ss_sync_d, ss_prev_q, ss_prev_d;
  logic flag_meta_q, flag_meta_d, flag_sync_q, flag_sync_d, flag_dly_q, flag_dly_d;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [NREGS*8-1:0] regs_q, regs_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               cmd_err_q, cmd_err_d;
  logic               busy_q, busy_d;

  logic       byte_evt_s;
  logic       ss_rise_s;
  logic [6:0] rsvd_s;
  logic       cmd_legal_s;

  // Synchroniser next values and derived event pulses.
  always_comb begin
    ss_meta_d   = SS;
    ss_sync_d   = ss_meta_q;
    ss_prev_d   = ss_sync_q;
    flag_meta_d = BYTE_FLAG;
    flag_sync_d = flag_meta_q;
    flag_dly_d  = flag_sync_q;
    // Gating with ss_sync_q means bytes seen while SS is (synchronised) high never count.
    byte_evt_s  = ~ss_sync_q & flag_sync_q & ~flag_dly_q;
    ss_rise_s   = ss_sync_q & ~ss_prev_q;
    // Reserved bits are [6:ADDR_W]; shifting keeps this valid for any ADDR_W.
    rsvd_s      = BYTE_IN[6:0] >> ADDR_W;
    cmd_legal_s = BYTE_IN[7] & (rsvd_s == 7'd0);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= ST_IDLE;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_prev_q   <= 1'b1;
      flag_meta_q <= 1'b0;
      flag_sync_q <= 1'b0;
      flag_dly_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= 8'h00;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      cmd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_meta_q   <= ss_meta_d;
      ss_sync_q   <= ss_sync_d;
      ss_prev_q   <= ss_prev_d;
      flag_meta_q <= flag_meta_d;
      flag_sync_q <= flag_sync_d;
      flag_dly_q  <= flag_dly_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      cmd_err_q   <= cmd_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; end of frame overrides everything, including a same-cycle byte.
  always_comb begin
    state_d = state_q;
    if (ss_rise_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (byte_evt_s) begin
            if (BYTE_IN == 8'h00) begin
              state_d = ST_IDLE;
            end else if (cmd_legal_s) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_DISCARD;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (byte_evt_s) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_COMMIT:  state_d = ST_DATA;
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    cmd_err_d   = 1'b0;
    busy_d      = (state_d != ST_IDLE);

    if ((state_q == ST_IDLE) && byte_evt_s && !ss_rise_s) begin
      if (BYTE_IN == 8'h00) begin
        cmd_err_d = 1'b0;
      end else if (cmd_legal_s) begin
        addr_d = BYTE_IN[ADDR_W-1:0];
      end else begin
        cmd_err_d = 1'b1;
      end
    end else if ((state_q == ST_DATA) && byte_evt_s && !ss_rise_s) begin
      data_d = BYTE_IN;
    end else if (state_q == ST_COMMIT) begin
      // A commit completes even when the frame ends in this same cycle.
      for (int i = 0; i < NREGS; i++) begin
        if (addr_q == ADDR_W'(i)) begin
          regs_d[i*8 +: 8] = data_q;
        end else begin
          regs_d[i*8 +: 8] = regs_q[i*8 +: 8];
        end
      end
      wr_strobe_d = 1'b1;
      wr_addr_d   = addr_q;
      // Power-of-two register count: natural overflow wraps to 0.
      addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      addr_d = addr_q;
    end
  end

  assign REGS      = regs_q;
  assign WR_STROBE = wr_strobe_q;
  assign WR_ADDR   = wr_addr_q;
  assign CMD_ERR   = cmd_err_q;
  assign BUSY      = busy_q;

endmodule
